// File: rtl/align_pattern_pkg.sv
// Shared encodings for the alignment training-pattern source.
package align_pattern_pkg;

   typedef enum logic [1:0] {
      MODE_IDLE = 2'd0,
      MODE_PRBS = 2'd1,
      MODE_CNT  = 2'd2,
      MODE_USER = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_OFF      = 2'd0,
      ST_PREAMBLE = 2'd1,
      ST_RUN      = 2'd2
   } state_e;

   localparam logic [7:0] PREAMBLE_WORD = 8'h55;

endpackage

// File: rtl/prbs7_gen.sv
// PRBS7 (x^7 + x^6 + 1, Fibonacci form) source yielding eight bits per advance;
// the first bit generated lands in word[7].
module prbs7_gen #(
   parameter logic [6:0] SEED = 7'h7F
) (
   input  logic       clk160,
   input  logic       totalCounterResetb_manual,
   input  logic       load,
   input  logic       advance,
   output logic [7:0] word
);

   logic [6:0] state_q;
   logic [6:0] state_nxt;

   // An all-zero state would lock up the LFSR, so it is treated as the seed.
   function automatic logic [14:0] step8(input logic [6:0] s_in);
      logic [6:0] s;
      logic [7:0] w;
      logic       b;
      s = (s_in == 7'd0) ? SEED : s_in;
      w = 8'd0;
      for (int i = 7; i >= 0; i--) begin
         b    = s[6] ^ s[5];
         w[i] = b;
         s    = {s[5:0], b};
      end
      return {w, s};
   endfunction

   assign {word, state_nxt} = step8(state_q);

   always_ff @(posedge clk160 or negedge totalCounterResetb_manual) begin
      if (!totalCounterResetb_manual) state_q <= SEED;
      else if (load)                  state_q <= SEED;
      else if (advance)               state_q <= state_nxt;
      else if (state_q == 7'd0)       state_q <= SEED;
   end

endmodule

// File: rtl/align_pattern_gen.sv
// Transmit-side training source: 8'h55 preamble followed by a selectable data
// pattern, with one-word error injection and saturating ground-truth counters.
import align_pattern_pkg::*;

module align_pattern_gen #(
   parameter int unsigned TRAIN_LEN = 64,
   parameter logic [6:0]  PRBS_SEED = 7'h7F,
   parameter logic [7:0]  IDLE_WORD = 8'hAC
) (
   input  logic        clk160,
   input  logic        totalCounterResetb_manual,
   input  logic        enable,
   input  logic [1:0]  mode,
   input  logic [7:0]  user_word,
   input  logic        train_start,
   input  logic        inject_error,
   input  logic        clear_counters,
   output logic [7:0]  data_out,
   output logic        data_valid,
   output logic        train_active,
   output logic [31:0] word_counter,
   output logic [31:0] injected_counter
);

   localparam logic [15:0] PRE_LAST = 16'(TRAIN_LEN - 1);

   state_e      state_q;
   logic [15:0] pre_cnt_q;
   logic [7:0]  cnt_pat_q;
   logic        restart_pend_q;
   logic        inj_pend_q;

   logic        enter_pre;
   logic        run_word;
   logic        inj_apply;
   logic        inj_accept;
   logic [7:0]  prbs_word;
   logic [7:0]  run_data;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Decide what the word registered on this edge will be.
   always_comb begin
      enter_pre = 1'b0;
      run_word  = 1'b0;
      if (enable) begin
         if (state_q == ST_OFF || restart_pend_q)
            enter_pre = 1'b1;
         else if (state_q == ST_RUN || pre_cnt_q == PRE_LAST)
            run_word = 1'b1;
      end
   end

   // A pending injection is discarded by a restart or by enable falling.
   assign inj_apply  = run_word && inj_pend_q;
   assign inj_accept = enable && (state_q == ST_RUN) && inject_error &&
                       !inj_pend_q && !restart_pend_q;

   prbs7_gen #(.SEED(PRBS_SEED)) u_prbs (
      .clk160                    (clk160),
      .totalCounterResetb_manual (totalCounterResetb_manual),
      .load                      (enter_pre),
      .advance                   (run_word && (mode == MODE_PRBS)),
      .word                      (prbs_word)
   );

   always_comb begin
      case (mode)
         MODE_IDLE: run_data = IDLE_WORD;
         MODE_PRBS: run_data = prbs_word;
         MODE_CNT:  run_data = cnt_pat_q;
         default:   run_data = user_word;
      endcase
   end

   always_ff @(posedge clk160 or negedge totalCounterResetb_manual) begin
      if (!totalCounterResetb_manual) begin
         state_q        <= ST_OFF;
         pre_cnt_q      <= 16'd0;
         cnt_pat_q      <= 8'd0;
         restart_pend_q <= 1'b0;
         inj_pend_q     <= 1'b0;
         data_out       <= 8'd0;
         data_valid     <= 1'b0;
         train_active   <= 1'b0;
      end else begin
         restart_pend_q <= enable && train_start && (state_q != ST_OFF);
         inj_pend_q     <= inj_accept;
         if (!enable) begin
            state_q      <= ST_OFF;
            data_out     <= 8'd0;
            data_valid   <= 1'b0;
            train_active <= 1'b0;
         end else if (enter_pre) begin
            state_q      <= ST_PREAMBLE;
            pre_cnt_q    <= 16'd0;
            cnt_pat_q    <= 8'd0;
            data_out     <= PREAMBLE_WORD;
            data_valid   <= 1'b0;
            train_active <= 1'b1;
         end else if (run_word) begin
            state_q      <= ST_RUN;
            data_out     <= run_data ^ {7'd0, inj_apply};
            data_valid   <= 1'b1;
            train_active <= 1'b0;
            if (mode == MODE_CNT) cnt_pat_q <= cnt_pat_q + 8'd1;
         end else begin
            pre_cnt_q    <= pre_cnt_q + 16'd1;
            data_out     <= PREAMBLE_WORD;
            data_valid   <= 1'b0;
            train_active <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk160 or negedge totalCounterResetb_manual) begin
      if (!totalCounterResetb_manual) begin
         word_counter     <= 32'd0;
         injected_counter <= 32'd0;
      end else if (clear_counters) begin
         word_counter     <= 32'd0;
         injected_counter <= 32'd0;
      end else begin
         if (run_word)  word_counter     <= sat_inc(word_counter);
         if (inj_apply) injected_counter <= sat_inc(injected_counter);
      end
   end

endmodule
